// File: rtl/timer_sched_pkg.sv
// Shared encodings for the timer event scheduler: tick base select, channel mode
// and output stage states.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    BASE_US   = 2'd0,
    BASE_MS   = 2'd1,
    BASE_SEC  = 2'd2,
    BASE_RSVD = 2'd3
  } base_e;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module sched_rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              any_req
);

  int              idx;
  logic [CH_W-1:0] idx_c;

  // Scan from the farthest slot back to ptr so the nearest requester is written last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    idx_c   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx   = (int'(ptr) + k) % NUM_CH;
      idx_c = CH_W'(idx);
      if (req[idx_c]) begin
        gnt        = '0;
        gnt[idx_c] = 1'b1;
        gnt_idx    = idx_c;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/timer_event_sched.sv
// Multi-channel timer scheduler: per-channel tick down-counters feed a one-deep
// pending flag each, drained round-robin onto a single valid/ready event port.
//
// state    | meaning
// ST_EMPTY | no event presented, evt_valid=0
// ST_FULL  | event held on evt_ch/evt_overrun until evt_ready
module timer_event_sched
  import timer_sched_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 16,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk_200,
  input  logic              resetb,
  input  logic              us_tick,
  input  logic              ms_tick,
  input  logic              sec_tick,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [1:0]        cfg_base,
  input  logic              cfg_mode,
  input  logic              cfg_en,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_overrun,
  output logic [NUM_CH-1:0] ch_active
);

  logic [NUM_CH-1:0] en, pending, overrun, gnt;
  logic [CH_W-1:0]   gnt_idx, rr_ptr;
  logic              any_req, load;
  out_state_e        state;

  sched_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (pending),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  assign load      = any_req && ((state == ST_EMPTY) || evt_ready);
  assign ch_active = en;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             cfg_hit, tick_sel, expire, ld_me;
    logic             en_q, pend_q, ovr_q;
    mode_e            mode_q;
    base_e            base_q;
    logic [CNT_W-1:0] period_q, count_q;

    assign cfg_hit = cfg_we && (cfg_ch == CH_W'(i));
    assign ld_me   = load && gnt[i];
    assign expire  = en_q && tick_sel && !cfg_hit && (count_q <= CNT_W'(1));

    always_comb begin
      case (base_q)
        BASE_US:  tick_sel = us_tick;
        BASE_MS:  tick_sel = ms_tick;
        BASE_SEC: tick_sel = sec_tick;
        default:  tick_sel = 1'b0;
      endcase
    end

    always_ff @(posedge clk_200 or negedge resetb) begin
      if (!resetb) begin
        en_q     <= 1'b0;
        base_q   <= BASE_US;
        mode_q   <= MODE_ONESHOT;
        period_q <= '0;
        count_q  <= '0;
        pend_q   <= 1'b0;
        ovr_q    <= 1'b0;
      end else if (cfg_hit) begin
        en_q     <= cfg_en;
        base_q   <= base_e'(cfg_base);
        mode_q   <= mode_e'(cfg_mode);
        period_q <= cfg_period;
        count_q  <= cfg_period;
        pend_q   <= 1'b0;
        ovr_q    <= 1'b0;
      end else begin
        if (en_q && tick_sel) begin
          if (count_q <= CNT_W'(1)) begin
            if (mode_q == MODE_PERIODIC) count_q <= period_q;
            else                         en_q    <= 1'b0;
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
        end
        // A fresh expiry while the old one is being unloaded is not a loss.
        if (expire) begin
          pend_q <= 1'b1;
          ovr_q  <= ld_me ? 1'b0 : (ovr_q | pend_q);
        end else if (ld_me) begin
          pend_q <= 1'b0;
          ovr_q  <= 1'b0;
        end
      end
    end

    assign en[i]      = en_q;
    assign pending[i] = pend_q;
    assign overrun[i] = ovr_q;
  end

  always_ff @(posedge clk_200 or negedge resetb) begin
    if (!resetb) begin
      state       <= ST_EMPTY;
      evt_valid   <= 1'b0;
      evt_ch      <= '0;
      evt_overrun <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (any_req) begin
            state     <= ST_FULL;
            evt_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (evt_ready && !any_req) begin
            state     <= ST_EMPTY;
            evt_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          evt_valid <= 1'b0;
        end
      endcase
      if (load) begin
        evt_ch      <= gnt_idx;
        evt_overrun <= |(overrun & gnt);
        rr_ptr      <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_timer_event_sched.sv
// Self-checking bench: directed scenarios plus random traffic against a
// per-cycle behavioural model of the scheduler.
module tb_timer_event_sched;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic        clk_200 = 1'b0;
  logic        resetb = 1'b0;
  logic        us_tick = 1'b0, ms_tick = 1'b0, sec_tick = 1'b0;
  logic        cfg_we = 1'b0, cfg_mode = 1'b0, cfg_en = 1'b0, evt_ready = 1'b0;
  logic [1:0]  cfg_ch = '0, cfg_base = '0;
  logic [15:0] cfg_period = '0;
  logic        evt_valid, evt_overrun;
  logic [1:0]  evt_ch;
  logic [3:0]  ch_active;

  int checks = 0;
  int errors = 0;

  always #5 clk_200 = ~clk_200;

  timer_event_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_200     (clk_200),
    .resetb      (resetb),
    .us_tick     (us_tick),
    .ms_tick     (ms_tick),
    .sec_tick    (sec_tick),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_base    (cfg_base),
    .cfg_mode    (cfg_mode),
    .cfg_en      (cfg_en),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_ch      (evt_ch),
    .evt_overrun (evt_overrun),
    .ch_active   (ch_active)
  );

  // Reference model: ticks left until expiry, queued event flag and lost flag per channel.
  int m_left[NUM_CH], m_per[NUM_CH], m_base[NUM_CH];
  bit m_en[NUM_CH], m_periodic[NUM_CH], m_pend[NUM_CH], m_lost[NUM_CH];
  bit o_valid, o_lost;
  int o_ch, m_next;

  // Events actually handed over by the DUT.
  int n_acc;
  int d_ch[$];
  int d_ov[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_left[c] = 0; m_per[c] = 0; m_base[c] = 0;
      m_en[c] = 0; m_periodic[c] = 0; m_pend[c] = 0; m_lost[c] = 0;
    end
    o_valid = 0; o_lost = 0; o_ch = 0; m_next = 0;
  endfunction

  function automatic logic [3:0] model_active();
    logic [3:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_en[c];
    return v;
  endfunction

  function automatic void model_step();
    int w;
    bit tk;
    w = -1;
    if (!o_valid || evt_ready) begin
      for (int k = 0; k < NUM_CH; k++)
        if (w < 0 && m_pend[(m_next + k) % NUM_CH]) w = (m_next + k) % NUM_CH;
      if (w >= 0) begin
        o_valid = 1; o_ch = w; o_lost = m_lost[w];
        m_next = (w + 1) % NUM_CH;
        m_pend[w] = 0; m_lost[w] = 0;
      end else begin
        o_valid = 0;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      tk = (m_base[c] == 0 && us_tick) || (m_base[c] == 1 && ms_tick) ||
           (m_base[c] == 2 && sec_tick);
      if (cfg_we && int'(cfg_ch) == c) begin
        m_en[c] = cfg_en; m_per[c] = int'(cfg_period); m_left[c] = int'(cfg_period);
        m_base[c] = int'(cfg_base); m_periodic[c] = cfg_mode;
        m_pend[c] = 0; m_lost[c] = 0;
      end else if (m_en[c] && tk) begin
        if (m_left[c] <= 1) begin
          if (m_pend[c]) m_lost[c] = 1;
          m_pend[c] = 1;
          if (m_periodic[c]) m_left[c] = m_per[c];
          else m_en[c] = 0;
        end else begin
          m_left[c] = m_left[c] - 1;
        end
      end
    end
  endfunction

  // One clock: inputs already applied, advance model, cross the edge, compare.
  task automatic step();
    if (evt_valid === 1'b1 && evt_ready) begin
      n_acc++;
      d_ch.push_back(int'(evt_ch));
      d_ov.push_back(int'(evt_overrun));
    end
    model_step();
    @(negedge clk_200);
    cfg_we = 0; us_tick = 0; ms_tick = 0; sec_tick = 0;
    chk("evt_valid", evt_valid, o_valid);
    if (o_valid) begin
      chk("evt_ch", evt_ch, o_ch);
      chk("evt_overrun", evt_overrun, o_lost);
    end
    chk("ch_active", ch_active, model_active());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg(input int ch, input int per, input int base, input bit mode, input bit en);
    cfg_we = 1; cfg_ch = 2'(ch); cfg_period = 16'(per);
    cfg_base = 2'(base); cfg_mode = mode; cfg_en = en;
    step();
  endtask

  task automatic us_pulses(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      us_tick = 1;
      step();
      idle(gap - 1);
    end
  endtask

  task automatic ms_pulses(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      ms_tick = 1;
      step();
      idle(gap - 1);
    end
  endtask

  function automatic void clear_log();
    d_ch.delete();
    d_ov.delete();
    n_acc = 0;
  endfunction

  initial begin
    int n0;
    model_reset();
    clear_log();
    repeat (2) @(negedge clk_200);
    chk("reset_valid", evt_valid, 0);
    chk("reset_ch", evt_ch, 0);
    chk("reset_overrun", evt_overrun, 0);
    chk("reset_active", ch_active, 0);
    resetb = 1;

    // All four channels expire on one tick: drained ch0..3, twice.
    evt_ready = 1;
    for (int c = 0; c < NUM_CH; c++) cfg(c, 1, 0, 1'b1, 1'b1);
    for (int r = 0; r < 2; r++) begin
      clear_log();
      us_pulses(1, 7);
      chk("rr_count", d_ch.size(), 4);
      for (int i = 0; i < 4 && i < d_ch.size(); i++) chk("rr_order", d_ch[i], i);
    end
    for (int c = 0; c < NUM_CH; c++) cfg(c, 1, 0, 1'b1, 1'b0);

    // Periodic period 3 on us ticks.
    clear_log();
    cfg(0, 3, 0, 1'b1, 1'b1);
    us_pulses(9, 4);
    idle(3);
    chk("periodic_count", n_acc, 3);
    for (int i = 0; i < d_ov.size(); i++) chk("periodic_ov", d_ov[i], 0);
    cfg(0, 3, 0, 1'b1, 1'b0);

    // One-shot period 2 on ms ticks.
    clear_log();
    cfg(1, 2, 1, 1'b0, 1'b1);
    ms_pulses(2, 4);
    chk("oneshot_inactive", ch_active[1], 0);
    ms_pulses(5, 4);
    chk("oneshot_count", n_acc, 1);

    // Stall with a backlog: held event, then one overrun event.
    clear_log();
    evt_ready = 0;
    cfg(2, 1, 0, 1'b1, 1'b1);
    us_pulses(3, 3);
    chk("stall_none", n_acc, 0);
    evt_ready = 1;
    idle(4);
    chk("stall_count", d_ch.size(), 2);
    if (d_ov.size() == 2) begin
      chk("stall_ov0", d_ov[0], 0);
      chk("stall_ov1", d_ov[1], 1);
    end
    cfg(2, 1, 0, 1'b1, 1'b0);

    // Config write on the expiring tick wins and restarts the period.
    clear_log();
    cfg(0, 2, 0, 1'b1, 1'b1);
    us_pulses(1, 3);
    us_tick = 1;
    cfg(0, 4, 0, 1'b1, 1'b1);
    idle(3);
    us_pulses(3, 3);
    chk("cfg_wins_none", n_acc, 0);
    us_pulses(1, 4);
    chk("cfg_wins_one", n_acc, 1);
    cfg(0, 4, 0, 1'b1, 1'b0);

    // Asynchronous reset while an event is presented and another is queued.
    evt_ready = 0;
    cfg(0, 1, 0, 1'b1, 1'b1);
    cfg(1, 1, 0, 1'b1, 1'b1);
    us_pulses(1, 3);
    chk("pre_reset_valid", evt_valid, 1);
    #1 resetb = 0;
    #1;
    chk("async_valid", evt_valid, 0);
    chk("async_ch", evt_ch, 0);
    chk("async_overrun", evt_overrun, 0);
    chk("async_active", ch_active, 0);
    model_reset();
    @(negedge clk_200);
    resetb = 1;
    evt_ready = 1;
    clear_log();
    us_pulses(4, 3);
    chk("post_reset_none", n_acc, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      us_tick   = ($urandom % 3) == 0;
      ms_tick   = ($urandom % 11) == 0;
      sec_tick  = ($urandom % 29) == 0;
      evt_ready = ($urandom % 4) != 0;
      if (($urandom % 8) == 0) begin
        cfg_we = 1; cfg_ch = 2'($urandom % 4);
        cfg_period = 16'($urandom % 5); cfg_base = 2'($urandom % 4);
        cfg_mode = 1'($urandom % 2); cfg_en = ($urandom % 4) != 0;
      end
      step();
    end
    n0 = n_acc;
    evt_ready = 1;
    idle(6);
    chk("drain_progress", (n_acc >= n0) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
